nrzi_tx: RTL and testbench

Transmit line encoder for the USB host datapath. It sits directly downstream of the bit stuffer and consumes its stuffed serial stream. It NRZI-encodes the stream onto the D+/D- pair and appends the end-of-packet sequence (SE0, SE0, J). The line idles in J between packets.

---
 rtl/usb_pkg.sv | 33 +++
 rtl/nrzi_enc.sv | 26 ++
 rtl/nrzi_tx.sv | 111 +++++++++++
 tb/tb_nrzi_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB line-state types and constants
package usb_pkg;

   typedef enum logic [1:0] {
      J   = 2'd0,
      K   = 2'd1,
      SE0 = 2'd2,
      SE1 = 2'd3
   } line_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_SE0   = 2'd2,
      ST_EOP_J = 2'd3
   } nrzi_tx_state_t;

   localparam logic J_DP = 1'b1;
   localparam logic J_DM = 1'b0;

   // Returns {dp, dm} for a line state
   function automatic logic [1:0] line_pins(input line_t l);
      logic [1:0] p;
      case (l)
         J:       p = {J_DP, J_DM};
         K:       p = {~J_DP, ~J_DM};
         SE0:     p = 2'b00;
         default: p = 2'b11;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/nrzi_enc.sv
// rtl/nrzi_enc.sv - NRZI level register; level 1 is J, 0 is K
module nrzi_enc (
   input  logic clk,
   input  logic rst_L,
   input  logic en,
   input  logic load_j,
   input  logic inb,
   output logic level_nxt
);

   logic level_q;

   // A 0 toggles the line, a 1 holds it; load_j encodes relative to J
   always_comb begin
      level_nxt = (load_j ? 1'b1 : level_q) ^ ~inb;
   end

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         level_q <= 1'b1;
      end else if (en) begin
         level_q <= level_nxt;
      end
   end

endmodule

// File: rtl/nrzi_tx.sv
// rtl/nrzi_tx.sv - NRZI line encoder with EOP generation; NRZI_TX_OE_EN adds pad output enable
module nrzi_tx
   import usb_pkg::*;
#(
   parameter int EOP_SE0_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_L,
   input  logic inb,
   input  logic sending,
   output logic dp,
   output logic dm,
   output logic busy,
`ifdef NRZI_TX_OE_EN
   output logic done,
   output logic oe
`else
   output logic done
`endif
);

   localparam logic [1:0] SE0_LAST = 2'(EOP_SE0_CYCLES);

   nrzi_tx_state_t state, state_nxt;
   logic [1:0]     se0_cnt, cnt_nxt;
   line_t          line_nxt;
   logic           busy_nxt, done_nxt;
   logic           enc_en, enc_load_j, level_nxt;

   nrzi_enc u_enc (
      .clk       (clk),
      .rst_L     (rst_L),
      .en        (enc_en),
      .load_j    (enc_load_j),
      .inb       (inb),
      .level_nxt (level_nxt)
   );

   // Line outputs are decided on the same edge as the state transition
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = se0_cnt;
      line_nxt   = J;
      busy_nxt   = 1'b1;
      done_nxt   = 1'b0;
      enc_en     = 1'b0;
      enc_load_j = 1'b0;
      case (state)
         ST_IDLE: begin
            busy_nxt   = 1'b0;
            enc_load_j = 1'b1;
            if (sending) begin
               enc_en    = 1'b1;
               line_nxt  = level_nxt ? J : K;
               busy_nxt  = 1'b1;
               cnt_nxt   = 2'd0;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sending) begin
               enc_en   = 1'b1;
               line_nxt = level_nxt ? J : K;
            end else begin
               line_nxt  = SE0;
               cnt_nxt   = 2'd1;
               state_nxt = (SE0_LAST == 2'd1) ? ST_EOP_J : ST_SE0;
            end
         end
         ST_SE0: begin
            line_nxt = SE0;
            cnt_nxt  = se0_cnt + 2'd1;
            if (se0_cnt + 2'd1 == SE0_LAST) begin
               state_nxt = ST_EOP_J;
            end
         end
         ST_EOP_J: begin
            line_nxt  = J;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state    <= ST_IDLE;
         se0_cnt  <= 2'd0;
         {dp, dm} <= line_pins(J);
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         se0_cnt  <= cnt_nxt;
         {dp, dm} <= line_pins(line_nxt);
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

`ifdef NRZI_TX_OE_EN
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         oe <= 1'b0;
      end else begin
         oe <= busy_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_nrzi_tx.sv
// tb/tb_nrzi_tx.sv - randomized bench for nrzi_tx against a packet-level line model
module tb_nrzi_tx;

   localparam int EOP_N = 2;

   logic clk = 1'b0;
   logic rst_L = 1'b0;
   logic inb = 1'b0;
   logic sending = 1'b0;
   logic dp, dm, busy, done;
`ifdef NRZI_TX_OE_EN
   logic oe;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct packed {
      logic s;
      logic b;
   } stim_t;

   stim_t      stim_q[$];
   logic [3:0] exp_q[$];   // {dp, dm, busy, done}

   always #5 clk = ~clk;

   nrzi_tx #(.EOP_SE0_CYCLES(EOP_N)) dut (
      .clk     (clk),
      .rst_L   (rst_L),
      .inb     (inb),
      .sending (sending),
      .dp      (dp),
      .dm      (dm),
      .busy    (busy),
`ifdef NRZI_TX_OE_EN
      .done    (done),
      .oe      (oe)
`else
      .done    (done)
`endif
   );

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) begin
         stim_q.push_back('{s: 1'b0, b: 1'($urandom)});
         exp_q.push_back(4'b1000);
      end
   endtask

   // Packet model: bits[0] goes first; the line starts at J and each 0 flips it
   task automatic add_packet(input logic [63:0] bits, input int len, input bit noise);
      logic lvl;
      lvl = 1'b1;
      for (int i = 0; i < len; i++) begin
         if (!bits[i]) lvl = ~lvl;
         stim_q.push_back('{s: 1'b1, b: bits[i]});
         exp_q.push_back({lvl, ~lvl, 1'b1, 1'b0});
      end
      stim_q.push_back('{s: 1'b0, b: 1'($urandom)});
      for (int i = 0; i < EOP_N; i++) begin
         stim_q.push_back('{s: noise ? 1'($urandom) : 1'b0, b: 1'($urandom)});
         exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b1011);
   endtask

   task automatic play(input string name);
      stim_t      s;
      logic [3:0] e;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         sending = s.s;
         inb = s.b;
         @(posedge clk);
         #1;
         cyc++;
         n_checks++;
         if ({dp, dm, busy, done} !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: dp/dm/busy/done=%b required %b", name, cyc, {dp, dm, busy, done}, e);
         end
`ifdef NRZI_TX_OE_EN
         n_checks++;
         if (oe !== e[1]) begin
            n_fail++;
            $display("FAIL %s_oe cycle %0d: oe=%b required %b", name, cyc, oe, e[1]);
         end
`endif
      end
   endtask

   task automatic test_reset();
      rst_L = 1'b0;
      sending = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({dp, dm, busy, done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset cycle %0d: dp/dm/busy/done=%b required 1000", i, {dp, dm, busy, done});
         end
      end
      rst_L = 1'b1;
      add_idle(3);
      play("reset_release");
   endtask

   task automatic test_sync();
      add_packet(64'h80, 8, 1'b0);
      add_idle(2);
      play("sync");
   endtask

   task automatic test_short();
      add_packet(64'hB, 4, 1'b0);
      add_idle(2);
      play("short");
   endtask

   task automatic test_back_to_back();
      add_packet({$urandom, $urandom}, $urandom_range(3, 20), 1'b0);
      add_packet({$urandom, $urandom}, $urandom_range(3, 20), 1'b0);
      add_packet(64'h0, 5, 1'b1);
      add_idle(2);
      play("back_to_back");
   endtask

   task automatic test_random();
      for (int p = 0; p < 12; p++) begin
         add_idle($urandom_range(0, 3));
         add_packet({$urandom, $urandom}, $urandom_range(1, 64), 1'b1);
      end
      add_idle(3);
      play("random");
   endtask

   task automatic test_reset_mid();
      logic lvl;
      logic b;
      add_idle(1);
      play("pre_mid_reset");
      lvl = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b = 1'($urandom);
         if (!b) lvl = ~lvl;
         sending = 1'b1;
         inb = b;
         @(posedge clk);
         #1;
         n_checks++;
         if ({dp, dm, busy, done} !== {lvl, ~lvl, 2'b10}) begin
            n_fail++;
            $display("FAIL mid_data bit %0d: dp/dm/busy/done=%b required %b", i, {dp, dm, busy, done}, {lvl, ~lvl, 2'b10});
         end
      end
      rst_L = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({dp, dm, busy, done} !== 4'b1000) begin
         n_fail++;
         $display("FAIL mid_reset: dp/dm/busy/done=%b required 1000", {dp, dm, busy, done});
      end
      rst_L = 1'b1;
      sending = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({dp, dm, busy, done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL post_mid_reset cycle %0d: dp/dm/busy/done=%b required 1000", i, {dp, dm, busy, done});
         end
      end
      add_packet({$urandom, $urandom}, 10, 1'b0);
      add_idle(2);
      play("after_mid_reset");
   endtask

   initial begin
      test_reset();
      test_sync();
      test_short();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
